// File: rtl/up_down_counter_bank.sv
// up_down_counter_bank
// Bank of CHANNELS independent up/down counters, each WIDTH bits wide, that
// count within 0..max_val. Each channel supports parallel load, registered
// overflow/underflow pulses and sticky flags that hold until cleared.
// Build option: define UDC_SATURATE_EN to saturate at the boundaries;
// leave it undefined (default) to wrap.
module up_down_counter_bank #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       up,
  input  logic [CHANNELS-1:0]       down,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] load_data,
  input  logic [WIDTH-1:0]          max_val,
  input  logic                      clr_sticky,
  output logic [CHANNELS*WIDTH-1:0] out,
  output logic [CHANNELS-1:0]       ovf,
  output logic [CHANNELS-1:0]       unf,
  output logic [CHANNELS-1:0]       sticky_ovf,
  output logic [CHANNELS-1:0]       sticky_unf,
  output logic [CHANNELS-1:0]       at_max,
  output logic [CHANNELS-1:0]       at_zero
);

`ifdef UDC_SATURATE_EN
  localparam bit SATURATE = 1'b1;
`else
  localparam bit SATURATE = 1'b0;
`endif

  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [CHANNELS-1:0][WIDTH-1:0] cnt_r;
  logic [CHANNELS-1:0][WIDTH-1:0] cnt_nxt_s;
  logic [CHANNELS-1:0]            ovf_r;
  logic [CHANNELS-1:0]            unf_r;
  logic [CHANNELS-1:0]            ovf_nxt_s;
  logic [CHANNELS-1:0]            unf_nxt_s;
  logic [CHANNELS-1:0]            sticky_ovf_r;
  logic [CHANNELS-1:0]            sticky_unf_r;
  logic [CHANNELS-1:0]            keep_mask_s;

  // Per-channel next count and terminal events: load > up-only > down-only > hold.
  always_comb begin
    cnt_nxt_s = cnt_r;
    ovf_nxt_s = {CHANNELS{1'b0}};
    unf_nxt_s = {CHANNELS{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      if (load[i]) begin
        // Loads are clamped to the terminal value and never raise an event.
        if (load_data[i*WIDTH +: WIDTH] > max_val) begin
          cnt_nxt_s[i] = max_val;
        end else begin
          cnt_nxt_s[i] = load_data[i*WIDTH +: WIDTH];
        end
      end else if (up[i] && !down[i]) begin
        // ">=" so a count left above a lowered max_val still terminates.
        if (cnt_r[i] >= max_val) begin
          ovf_nxt_s[i] = 1'b1;
          if (SATURATE) begin
            cnt_nxt_s[i] = max_val;
          end else begin
            cnt_nxt_s[i] = ZERO_C;
          end
        end else begin
          cnt_nxt_s[i] = cnt_r[i] + ONE_C;
        end
      end else if (down[i] && !up[i]) begin
        if (cnt_r[i] == ZERO_C) begin
          unf_nxt_s[i] = 1'b1;
          if (SATURATE) begin
            cnt_nxt_s[i] = ZERO_C;
          end else begin
            cnt_nxt_s[i] = max_val;
          end
        end else begin
          cnt_nxt_s[i] = cnt_r[i] - ONE_C;
        end
      end else begin
        cnt_nxt_s[i] = cnt_r[i];
      end
    end
  end

  // Sticky flags keep their value unless cleared; a new pulse overrides the clear.
  always_comb begin
    keep_mask_s = {CHANNELS{1'b0}};
    if (clr_sticky) begin
      keep_mask_s = {CHANNELS{1'b0}};
    end else begin
      keep_mask_s = {CHANNELS{1'b1}};
    end
  end

  // Counter, pulse and sticky state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_r        <= {(CHANNELS*WIDTH){1'b0}};
      ovf_r        <= {CHANNELS{1'b0}};
      unf_r        <= {CHANNELS{1'b0}};
      sticky_ovf_r <= {CHANNELS{1'b0}};
      sticky_unf_r <= {CHANNELS{1'b0}};
    end else begin
      cnt_r        <= cnt_nxt_s;
      ovf_r        <= ovf_nxt_s;
      unf_r        <= unf_nxt_s;
      sticky_ovf_r <= ovf_nxt_s | (sticky_ovf_r & keep_mask_s);
      sticky_unf_r <= unf_nxt_s | (sticky_unf_r & keep_mask_s);
    end
  end

  // Boundary status decoded from the registered counts and the live max_val.
  always_comb begin
    at_max  = {CHANNELS{1'b0}};
    at_zero = {CHANNELS{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      at_max[i]  = (cnt_r[i] >= max_val);
      at_zero[i] = (cnt_r[i] == ZERO_C);
    end
  end

  assign out        = cnt_r;
  assign ovf        = ovf_r;
  assign unf        = unf_r;
  assign sticky_ovf = sticky_ovf_r;
  assign sticky_unf = sticky_unf_r;

endmodule

// File: tb/tb_up_down_counter_bank.sv
// Self-checking bench for up_down_counter_bank (WIDTH=8, CHANNELS=4).
// A table of sequential vectors covers reset, priority, independence,
// max_val=0 and sticky behaviour; hand-written sequences cover wrap/saturate.
module tb_up_down_counter_bank;

  localparam int W = 8;
  localparam int C = 4;

  logic           clk;
  logic           reset;
  logic [C-1:0]   up;
  logic [C-1:0]   down;
  logic [C-1:0]   load;
  logic [C*W-1:0] load_data;
  logic [W-1:0]   max_val;
  logic           clr_sticky;
  logic [C*W-1:0] out;
  logic [C-1:0]   ovf;
  logic [C-1:0]   unf;
  logic [C-1:0]   sticky_ovf;
  logic [C-1:0]   sticky_unf;
  logic [C-1:0]   at_max;
  logic [C-1:0]   at_zero;

  int checks = 0;
  int errors = 0;

  up_down_counter_bank #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk        (clk),
    .reset      (reset),
    .up         (up),
    .down       (down),
    .load       (load),
    .load_data  (load_data),
    .max_val    (max_val),
    .clr_sticky (clr_sticky),
    .out        (out),
    .ovf        (ovf),
    .unf        (unf),
    .sticky_ovf (sticky_ovf),
    .sticky_unf (sticky_unf),
    .at_max     (at_max),
    .at_zero    (at_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  up;
    logic [3:0]  dn;
    logic [3:0]  ld;
    logic [31:0] ldd;
    logic [7:0]  mx;
    logic        clr;
    logic [31:0] e_out;
    logic [3:0]  e_ovf;
    logic [3:0]  e_unf;
    logic [3:0]  e_sovf;
    logic [3:0]  e_sunf;
    logic [3:0]  e_amax;
    logic [3:0]  e_azero;
  } vec_t;

  localparam int NV = 23;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic rst, input logic [3:0] u, input logic [3:0] d,
                              input logic [3:0] l, input logic [31:0] ldd, input logic [7:0] mx,
                              input logic clr, input logic [31:0] eo, input logic [3:0] eov,
                              input logic [3:0] eun, input logic [3:0] eso, input logic [3:0] esu,
                              input logic [3:0] eam, input logic [3:0] eaz);
    vec_t v;
    v.rst = rst; v.up = u; v.dn = d; v.ld = l; v.ldd = ldd; v.mx = mx; v.clr = clr;
    v.e_out = eo; v.e_ovf = eov; v.e_unf = eun; v.e_sovf = eso; v.e_sunf = esu;
    v.e_amax = eam; v.e_azero = eaz;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it in, and settle just after the edge.
  task automatic step(input logic rst, input logic [3:0] u, input logic [3:0] d,
                      input logic [3:0] l, input logic [31:0] ldd, input logic [7:0] mx,
                      input logic clr);
    reset = rst; up = u; down = d; load = l; load_data = ldd; max_val = mx; clr_sticky = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; up = 4'h0; down = 4'h0; load = 4'h0;
    load_data = 32'h0; max_val = 8'd5; clr_sticky = 1'b0;

    //            rst  up    dn    ld    ldd           mx      clr   out           ovf   unf   sovf  sunf  amax  azero
    // reset held with up asserted, then release counts 1,2,3
    tbl[0]  = mk(1'b0, 4'hF, 4'h0, 4'h0, 32'h0,        8'd5,   1'b0, 32'h00000000, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF);
    tbl[1]  = mk(1'b0, 4'hF, 4'h0, 4'h0, 32'h0,        8'd5,   1'b0, 32'h00000000, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF);
    tbl[2]  = mk(1'b0, 4'hF, 4'h0, 4'h0, 32'h0,        8'd5,   1'b0, 32'h00000000, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF);
    tbl[3]  = mk(1'b1, 4'hF, 4'h0, 4'h0, 32'h0,        8'd5,   1'b0, 32'h01010101, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    tbl[4]  = mk(1'b1, 4'hF, 4'h0, 4'h0, 32'h0,        8'd5,   1'b0, 32'h02020202, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    tbl[5]  = mk(1'b1, 4'hF, 4'h0, 4'h0, 32'h0,        8'd5,   1'b0, 32'h03030303, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    // independence: ch1 loaded with 3, then ch0 up / ch1 down / ch2 load 7 / ch3 idle x2
    tbl[6]  = mk(1'b0, 4'h0, 4'h0, 4'h0, 32'h0,        8'd5,   1'b0, 32'h00000000, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF);
    tbl[7]  = mk(1'b1, 4'h0, 4'h0, 4'h2, 32'h00000300, 8'd5,   1'b0, 32'h00000300, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hD);
    tbl[8]  = mk(1'b1, 4'h1, 4'h2, 4'h4, 32'h00070000, 8'd10,  1'b0, 32'h00070201, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8);
    tbl[9]  = mk(1'b1, 4'h1, 4'h2, 4'h4, 32'h00070000, 8'd10,  1'b0, 32'h00070102, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8);
    // priority: load 200 clamped to 100 beats up, then up&down holds
    tbl[10] = mk(1'b1, 4'h1, 4'h0, 4'h1, 32'h000000C8, 8'd100, 1'b0, 32'h00070164, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h8);
    tbl[11] = mk(1'b1, 4'h1, 4'h1, 4'h0, 32'h0,        8'd100, 1'b0, 32'h00070164, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h8);
    // lowered max_val: at_max follows combinationally; down above max decrements
    tbl[12] = mk(1'b1, 4'h0, 4'h0, 4'h0, 32'h0,        8'd2,   1'b0, 32'h00070164, 4'h0, 4'h0, 4'h0, 4'h0, 4'h5, 4'h8);
    tbl[13] = mk(1'b1, 4'h0, 4'h1, 4'h0, 32'h0,        8'd2,   1'b0, 32'h00070163, 4'h0, 4'h0, 4'h0, 4'h0, 4'h5, 4'h8);
    // max_val = 0 and sticky behaviour (count stays 0 in both build modes)
    tbl[14] = mk(1'b0, 4'h0, 4'h0, 4'h0, 32'h0,        8'd0,   1'b0, 32'h00000000, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF);
    tbl[15] = mk(1'b1, 4'h4, 4'h0, 4'h0, 32'h0,        8'd0,   1'b1, 32'h00000000, 4'h4, 4'h0, 4'h4, 4'h0, 4'hF, 4'hF);
    tbl[16] = mk(1'b1, 4'h0, 4'h0, 4'h0, 32'h0,        8'd0,   1'b1, 32'h00000000, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF);
    tbl[17] = mk(1'b1, 4'h0, 4'h8, 4'h0, 32'h0,        8'd0,   1'b0, 32'h00000000, 4'h0, 4'h8, 4'h0, 4'h8, 4'hF, 4'hF);
    tbl[18] = mk(1'b1, 4'h0, 4'h0, 4'h0, 32'h0,        8'd0,   1'b0, 32'h00000000, 4'h0, 4'h0, 4'h0, 4'h8, 4'hF, 4'hF);
    tbl[19] = mk(1'b1, 4'h1, 4'h2, 4'h0, 32'h0,        8'd0,   1'b0, 32'h00000000, 4'h1, 4'h2, 4'h1, 4'hA, 4'hF, 4'hF);
    tbl[20] = mk(1'b1, 4'h1, 4'h0, 4'h0, 32'h0,        8'd0,   1'b1, 32'h00000000, 4'h1, 4'h0, 4'h1, 4'h0, 4'hF, 4'hF);
    tbl[21] = mk(1'b1, 4'h0, 4'h0, 4'hF, 32'hFFFFFFFF, 8'd0,   1'b0, 32'h00000000, 4'h0, 4'h0, 4'h1, 4'h0, 4'hF, 4'hF);
    // reset overrides same-cycle load and up, and clears sticky
    tbl[22] = mk(1'b0, 4'hF, 4'h0, 4'hF, 32'h12345678, 8'd0,   1'b0, 32'h00000000, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF);

    @(negedge clk);
    for (int i = 0; i < NV; i++) begin
      step(tbl[i].rst, tbl[i].up, tbl[i].dn, tbl[i].ld, tbl[i].ldd, tbl[i].mx, tbl[i].clr);
      check($sformatf("v%0d out", i),        out,                tbl[i].e_out);
      check($sformatf("v%0d ovf", i),        {28'h0, ovf},        {28'h0, tbl[i].e_ovf});
      check($sformatf("v%0d unf", i),        {28'h0, unf},        {28'h0, tbl[i].e_unf});
      check($sformatf("v%0d sticky_ovf", i), {28'h0, sticky_ovf}, {28'h0, tbl[i].e_sovf});
      check($sformatf("v%0d sticky_unf", i), {28'h0, sticky_unf}, {28'h0, tbl[i].e_sunf});
      check($sformatf("v%0d at_max", i),     {28'h0, at_max},     {28'h0, tbl[i].e_amax});
      check($sformatf("v%0d at_zero", i),    {28'h0, at_zero},    {28'h0, tbl[i].e_azero});
    end

`ifdef UDC_SATURATE_EN
    // saturate: 8 ups from 0 with max 5; ovf on the 6th..8th
    step(1'b0, 4'h0, 4'h0, 4'h0, 32'h0, 8'd5, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 4'h1, 4'h0, 4'h0, 32'h0, 8'd5, 1'b0);
      check($sformatf("sat up%0d out", k), {24'h0, out[7:0]}, (k < 5) ? k : 5);
      check($sformatf("sat up%0d ovf", k), {31'h0, ovf[0]},   (k >= 6) ? 32'd1 : 32'd0);
    end
    check("sat sticky_ovf", {31'h0, sticky_ovf[0]}, 32'd1);
    step(1'b1, 4'h0, 4'h0, 4'h1, 32'h0, 8'd5, 1'b0);
    check("sat load0 out", {24'h0, out[7:0]}, 32'd0);
    step(1'b1, 4'h0, 4'h1, 4'h0, 32'h0, 8'd5, 1'b0);
    check("sat down0 out", {24'h0, out[7:0]}, 32'd0);
    check("sat down0 unf", {31'h0, unf[0]},   32'd1);
    step(1'b1, 4'h0, 4'h0, 4'h0, 32'h0, 8'd5, 1'b0);
    check("sat idle unf", {31'h0, unf[0]}, 32'd0);
    check("sat sticky_unf", {31'h0, sticky_unf[0]}, 32'd1);
`else
    // wrap: load 4, up to 5, up wraps to 0 with ovf, down wraps to 5 with unf
    step(1'b0, 4'h0, 4'h0, 4'h0, 32'h0, 8'd5, 1'b0);
    step(1'b1, 4'h0, 4'h0, 4'h1, 32'h00000004, 8'd5, 1'b0);
    check("wrap load out", {24'h0, out[7:0]}, 32'd4);
    step(1'b1, 4'h1, 4'h0, 4'h0, 32'h0, 8'd5, 1'b0);
    check("wrap up1 out", {24'h0, out[7:0]}, 32'd5);
    check("wrap up1 ovf", {31'h0, ovf[0]},   32'd0);
    check("wrap up1 at_max", {31'h0, at_max[0]}, 32'd1);
    step(1'b1, 4'h1, 4'h0, 4'h0, 32'h0, 8'd5, 1'b0);
    check("wrap up2 out", {24'h0, out[7:0]}, 32'd0);
    check("wrap up2 ovf", {31'h0, ovf[0]},   32'd1);
    check("wrap up2 sticky_ovf", {31'h0, sticky_ovf[0]}, 32'd1);
    step(1'b1, 4'h0, 4'h0, 4'h0, 32'h0, 8'd5, 1'b0);
    check("wrap idle ovf", {31'h0, ovf[0]}, 32'd0);
    check("wrap idle sticky_ovf", {31'h0, sticky_ovf[0]}, 32'd1);
    step(1'b1, 4'h0, 4'h1, 4'h0, 32'h0, 8'd5, 1'b0);
    check("wrap down out", {24'h0, out[7:0]}, 32'd5);
    check("wrap down unf", {31'h0, unf[0]},   32'd1);
    step(1'b1, 4'h0, 4'h0, 4'h0, 32'h0, 8'd5, 1'b0);
    check("wrap idle unf", {31'h0, unf[0]}, 32'd0);
    check("wrap other ch", out[31:8], 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/up_down_counter_bank.md
# up_down_counter_bank

Bank of `CHANNELS` independent up/down counters, each `WIDTH` bits, sharing one clock and a programmable terminal value `max_val`. It replaces single fixed 8-bit counter instances in the CDA block wherever several event tallies need parallel load, a bounded range and overflow/underflow reporting. Each channel counts in the range 0..`max_val`, at the boundaries either wrapping or saturating (build-time choice), and raises registered event pulses plus sticky flags.

## Interface
- `WIDTH`, 8: counter width per channel, ≥ 2.
- `CHANNELS`, 4: number of independent counters, ≥ 1.

- `clk` input 1: single clock, all state updates on rising edge.
- `reset` input 1: synchronous, active-low; sampled on `clk` rising edge.
- `up` input CHANNELS: per-channel count-up request.
- `down` input CHANNELS: per-channel count-down request.
- `load` input CHANNELS: per-channel parallel load strobe.
- `load_data` input CHANNELS*WIDTH: load values; channel i uses bits [i*WIDTH +: WIDTH].
- `max_val` input WIDTH: terminal count shared by all channels.
- `clr_sticky` input 1: clears all sticky flags.
- `out` output CHANNELS*WIDTH: count values, same packing as `load_data`.
- `ovf` output CHANNELS: one-cycle registered overflow pulse.
- `unf` output CHANNELS: one-cycle registered underflow pulse.
- `sticky_ovf` output CHANNELS: latched overflow flag.
- `sticky_unf` output CHANNELS: latched underflow flag.
- `at_max` output CHANNELS: combinational, count ≥ `max_val`.
- `at_zero` output CHANNELS: combinational, count == 0.

## Operation
- Per-channel priority on each edge: `reset` low > `load` > (`up` & !`down`) > (`down` & !`up`) > hold.
- `up` and `down` both high: hold; no event.
- Load: count ← min(`load_data`_i, `max_val`). Load never raises `ovf`/`unf`.
- Up with count < `max_val`: count + 1.
- Up with count ≥ `max_val`: terminal event. `ovf`_i = 1 for the next cycle. Count handling depends on configuration (see Configuration).
- Down with count > 0: count − 1, even if the count is above `max_val` after `max_val` was lowered.
- Down with count == 0: terminal event. `unf`_i = 1 for the next cycle. Count handling depends on configuration.
- `max_val` = 0: the channel is held at 0. Every up asserts `ovf` and every down asserts `unf`.
- Arithmetic is unsigned modulo 2^WIDTH internally. The count never leaves 0..max(`max_val`, previous count).
- Sticky flags: set on any cycle the matching pulse is generated. They clear when `clr_sticky` = 1. If set and clear happen in the same cycle, set wins.
- Channels are fully independent. `max_val` and `clr_sticky` are the only shared controls.

## Timing
- Reset (`reset` = 0 at an edge) values: `out` = 0, `ovf` = 0, `unf` = 0, `sticky_ovf` = 0, `sticky_unf` = 0. After reset, `at_zero` is all-ones, and `at_max` = 1 only where `max_val` = 0.
- Reset mid-count overrides a same-cycle `load`, `up` and `down`. No event is generated.
- Latency: the new count appears one cycle after the request is sampled. `ovf`/`unf` are asserted in that same cycle and deassert one cycle later unless the event repeats.
- Continuous up at terminal: `ovf` stays high every cycle.
- `at_max`/`at_zero` are combinational from registered count and `max_val`. A `max_val` change is reflected in the same cycle.
- No handshake. Requests are level-sampled every edge.

## Configuration
- `UDC_SATURATE_EN` defined: terminal events saturate.
  - Up at terminal: count ← `max_val`.
  - Down at 0: count stays 0.
  - Pulses and sticky flags still assert.
- `UDC_SATURATE_EN` undefined (default): terminal events wrap.
  - Up at terminal: count ← 0.
  - Down at 0: count ← `max_val`.

## Test plan
- Reset: hold `reset` = 0 with `up` all-ones for 3 cycles → `out` = 0 and all flags 0 throughout. Release → channel counts 1, 2, 3 on successive cycles.
- Wrap (macro off), `WIDTH` = 8, `max_val` = 5: load 4 then up ×2 → out 5, then 0 with `ovf` = 1 for one cycle and `sticky_ovf` = 1. Then down → out 5 with `unf` = 1.
- Saturate (`UDC_SATURATE_EN`), `max_val` = 5: up ×8 from 0 → out stays 5. `ovf` is high on cycles 6–8. Then down at 0 → out 0 with `unf` = 1.
- Priority: same cycle `load` = 1, `load_data` = 200, `max_val` = 100, `up` = 1 → out = 100, no `ovf`. Then `up` = `down` = 1 → hold at 100.
- Sticky: generate `ovf` on channel 2 while asserting `clr_sticky` that cycle → `sticky_ovf`[2] = 1. Next cycle `clr_sticky` alone → 0.
- Independence, `CHANNELS` = 4: ch0 up, ch1 down from 3, ch2 load 7, ch3 idle for 2 cycles → out = {ch3: 0, ch2: 7, ch1: 1, ch0: 2}.
